// File: rtl/button_bank.sv
`default_nettype none
// ============================================================================
// button_bank: N-channel push-button front end (sync, debounce, press/release
// pulses, long-press detect, toggle).                            Rev 1.0
// ============================================================================
module button_bank #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 1000000,
    parameter int LONG_CYCLES = 100000000
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N_CH-1:0] btn_in_i,
    input  logic [N_CH-1:0] toggle_clr_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] long_press_o,
    output logic [N_CH-1:0] toggle_o
);
    localparam int c_dcw = $clog2(DB_CYCLES + 1);
    localparam int c_hcw = $clog2(LONG_CYCLES + 1);

    localparam logic [c_dcw-1:0] c_dc_last = c_dcw'(DB_CYCLES - 1);
    localparam logic [c_dcw-1:0] c_dc_one  = c_dcw'(1);
    localparam logic [c_hcw-1:0] c_hc_max  = c_hcw'(LONG_CYCLES);
    localparam logic [c_hcw-1:0] c_hc_last = c_hcw'(LONG_CYCLES - 1);
    localparam logic [c_hcw-1:0] c_hc_one  = c_hcw'(1);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [c_dcw-1:0]       dc_q, dc_d;
        logic [c_hcw-1:0]       hc_q, hc_d;
        logic                   level_q, level_d;
        logic                   press_q, press_d;
        logic                   rel_q, rel_d;
        logic                   long_q, long_d;
        logic                   tog_q, tog_d;
        logic                   s;
        logic                   accept;

        always_comb begin
            s       = sync_q[SYNC_STAGES-1];
            // The new level is taken on the DB_CYCLES-th consecutive edge that sees it.
            accept  = (s != level_q) && (dc_q == c_dc_last);
            dc_d    = '0;
            if ((s != level_q) && !accept) begin
                dc_d = dc_q + c_dc_one;
            end
            level_d = accept ? s : level_q;
            press_d = accept & s;
            rel_d   = accept & ~s;

            hc_d = '0;
            if (level_q) begin
                hc_d = (hc_q == c_hc_max) ? hc_q : hc_q + c_hc_one;
            end
            // A release landing on the final hold edge cancels the long press.
            long_d = level_q & ~rel_d & (hc_q == c_hc_last);

            tog_d = toggle_clr_i[g] ? 1'b0 : (tog_q ^ press_q);
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                sync_q  <= '0;
                dc_q    <= '0;
                hc_q    <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                tog_q   <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in_i[g]};
                dc_q    <= dc_d;
                hc_q    <= hc_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
                tog_q   <= tog_d;
            end
        end

        assign level_o[g]      = level_q;
        assign press_o[g]      = press_q;
        assign release_o[g]    = rel_q;
        assign long_press_o[g] = long_q;
        assign toggle_o[g]     = tog_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_bank.sv
`default_nettype none
// ============================================================================
// tb_button_bank: vector table plus pulse scoreboard for button_bank.  Rev 1.0
// ============================================================================
module tb_button_bank;
    localparam int N_CH        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 8;
    localparam int LONG_CYCLES = 32;
    localparam int LAT         = SYNC_STAGES + DB_CYCLES;

    logic            clk;
    logic            reset;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] clr;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] rel;
    logic [N_CH-1:0] lng;
    logic [N_CH-1:0] tog;

    button_bank #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .btn_in_i     (btn),
        .toggle_clr_i (clr),
        .level_o      (level),
        .press_o      (press),
        .release_o    (rel),
        .long_press_o (lng),
        .toggle_o     (tog)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 press, 1 release, 2 long_press
    } ev_t;

    typedef struct {
        logic [N_CH-1:0] btn;
        logic [N_CH-1:0] clr;
        int              steps;
        logic [N_CH-1:0] lvl;
        logic [N_CH-1:0] tg;
        logic [N_CH-1:0] pm;
        logic [N_CH-1:0] rm;
        logic [N_CH-1:0] lm;
    } vec_t;

    ev_t  sbq[$];
    vec_t vecs[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int ev_key(ev_t e);
        return e.cyc * 16 + e.kind * 4 + e.ch;
    endfunction

    function automatic void push_ev(int c, int ch, int kind);
        ev_t e;
        int  pos;
        e.cyc  = c;
        e.ch   = ch;
        e.kind = kind;
        pos = sbq.size();
        for (int i = 0; i < sbq.size(); i++) begin
            if (ev_key(sbq[i]) > ev_key(e)) begin
                pos = i;
                break;
            end
        end
        sbq.insert(pos, e);
    endfunction

    function automatic void push_mask(int c, logic [N_CH-1:0] m, int kind);
        for (int ch = 0; ch < N_CH; ch++) begin
            if (m[ch]) push_ev(c, ch, kind);
        end
    endfunction

    function automatic void add_vec(logic [N_CH-1:0] b, logic [N_CH-1:0] c, int steps,
                                    logic [N_CH-1:0] lvl, logic [N_CH-1:0] tg,
                                    logic [N_CH-1:0] pm, logic [N_CH-1:0] rm,
                                    logic [N_CH-1:0] lm);
        vec_t v;
        v.btn = b;  v.clr = c;  v.steps = steps;
        v.lvl = lvl; v.tg = tg;
        v.pm = pm;  v.rm = rm;  v.lm = lm;
        vecs.push_back(v);
    endfunction

    task automatic check4(string name, logic [N_CH-1:0] act, logic [N_CH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock edge, then compare every pulse seen against the scoreboard.
    task automatic step();
        logic [N_CH-1:0] pulses [3];
        @(posedge clk);
        #1;
        cyc++;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_pulse kind=%0d ch=%0d: expected at cycle %0d, not seen",
                     sbq[0].kind, sbq[0].ch, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        pulses[0] = press;
        pulses[1] = rel;
        pulses[2] = lng;
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (pulses[k][ch] === 1'b1) begin
                    n_tests++;
                    if (sbq.size() > 0 && sbq[0].cyc == cyc && sbq[0].ch == ch &&
                        sbq[0].kind == k) begin
                        void'(sbq.pop_front());
                    end else begin
                        n_fail++;
                        $display("FAIL unexpected_pulse kind=%0d ch=%0d at cycle %0d: got 1 expected 0",
                                 k, ch, cyc);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        btn   = 4'hF;
        clr   = 4'h0;

        // Reset held with all buttons pressed.
        repeat (3) step();
        check4("reset_level",  level, 4'h0);
        check4("reset_toggle", tog,   4'h0);
        check4("reset_pulses", press | rel | lng, 4'h0);

        // Startup with all held, then release and clear toggles.
        add_vec(4'hF, 4'h0, LAT - 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add_vec(4'hF, 4'h0, 1,       4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
        add_vec(4'hF, 4'h0, 1,       4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, LAT,     4'h0, 4'hF, 4'h0, 4'hF, 4'h0);
        add_vec(4'h0, 4'hF, 1,       4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Channel 0: two clean press/release cycles.
        add_vec(4'h1, 4'h0, LAT - 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add_vec(4'h1, 4'h0, 1,       4'h1, 4'h0, 4'h1, 4'h0, 4'h0);
        add_vec(4'h1, 4'h0, 1,       4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, LAT - 1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, 1,       4'h0, 4'h1, 4'h0, 4'h1, 4'h0);
        add_vec(4'h1, 4'h0, LAT,     4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
        add_vec(4'h1, 4'h0, 1,       4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, LAT,     4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
        // Channel 1: one-short pulse and bouncing, never accepted.
        add_vec(4'h2, 4'h0, DB_CYCLES - 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, 3,             4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int r = 0; r < 10; r++) begin
            add_vec(4'h2, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
            add_vec(4'h0, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        end
        add_vec(4'h0, 4'h0, 5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Channel 2: long hold gives one long_press; short hold gives none.
        add_vec(4'h4, 4'h0, LAT,              4'h4, 4'h0, 4'h4, 4'h0, 4'h0);
        add_vec(4'h4, 4'h0, LONG_CYCLES,      4'h4, 4'h4, 4'h0, 4'h0, 4'h4);
        add_vec(4'h4, 4'h0, 60 - LONG_CYCLES, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, LAT,              4'h0, 4'h4, 4'h0, 4'h4, 4'h0);
        add_vec(4'h4, 4'h0, LAT,              4'h4, 4'h4, 4'h4, 4'h0, 4'h0);
        add_vec(4'h4, 4'h0, 10,               4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, LAT,              4'h0, 4'h0, 4'h0, 4'h4, 4'h0);
        add_vec(4'h0, 4'h0, 22,               4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // Channel 3: clear colliding with press, clear of a set toggle.
        add_vec(4'h8, 4'h0, LAT, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0);
        add_vec(4'h8, 4'h8, 1,   4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
        add_vec(4'h8, 4'h0, 1,   4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, LAT, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0);
        add_vec(4'h8, 4'h0, LAT, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0);
        add_vec(4'h8, 4'h0, 1,   4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
        add_vec(4'h8, 4'h8, 1,   4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, LAT, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0);
        // Channels 0 and 3 together.
        add_vec(4'h9, 4'h0, LAT, 4'h9, 4'h0, 4'h9, 4'h0, 4'h0);
        add_vec(4'h9, 4'h0, 1,   4'h9, 4'h9, 4'h0, 4'h0, 4'h0);
        add_vec(4'h0, 4'h0, LAT, 4'h0, 4'h9, 4'h0, 4'h9, 4'h0);
        add_vec(4'h0, 4'h9, 1,   4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            btn = vecs[i].btn;
            clr = vecs[i].clr;
            push_mask(cyc + vecs[i].steps, vecs[i].pm, 0);
            push_mask(cyc + vecs[i].steps, vecs[i].rm, 1);
            push_mask(cyc + vecs[i].steps, vecs[i].lm, 2);
            repeat (vecs[i].steps) step();
            check4($sformatf("vec%0d_level", i),  level, vecs[i].lvl);
            check4($sformatf("vec%0d_toggle", i), tog,   vecs[i].tg);
        end

        // Reset while channel 2 is held with 20 hold cycles accumulated.
        btn = 4'h4;
        clr = 4'h0;
        push_ev(cyc + LAT, 2, 0);
        repeat (LAT) step();
        repeat (20) step();
        check4("pre_reset_toggle", tog, 4'h4);
        reset = 1'b1;
        #1;
        check4("async_reset_level",  level, 4'h0);
        check4("async_reset_toggle", tog,   4'h0);
        check4("async_reset_pulses", press | rel | lng, 4'h0);
        repeat (3) step();
        reset = 1'b0;
        push_ev(cyc + LAT, 2, 0);
        push_ev(cyc + LAT + LONG_CYCLES, 2, 2);
        repeat (LAT + LONG_CYCLES) step();
        check4("post_reset_level",  level, 4'h4);
        check4("post_reset_toggle", tog,   4'h4);
        btn = 4'h0;
        push_ev(cyc + LAT, 2, 1);
        repeat (LAT + 2) step();
        check4("final_level", level, 4'h0);

        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_bank.md
Name: button_bank

Overview:
- Parametrised N-channel push-button front end: per-channel input synchroniser, counter-based debouncer, press/release edge pulses, long-press detection and a toggle register.
- Replaces per-button single-channel debounce instances plus ad-hoc toggle logic.
- Sits between the raw board buttons and the LED/control logic in the `clk_100` domain.
- All channels are identical and fully independent.

Parameters:
- N_CH, 4, number of button channels.
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz; >=1).
- LONG_CYCLES, 100000000, cycles the debounced level must stay high before `long_press` fires (1 s at 100 MHz; >=1).

Ports:
- clk  in  1  system clock (`clk_100` domain); all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- btn_in  in  N_CH  raw asynchronous button inputs, active-high.
- toggle_clr  in  N_CH  synchronous per-channel clear of `toggle`.
- level  out  N_CH  debounced button level.
- press  out  N_CH  1-cycle pulse on debounced rising edge.
- release  out  N_CH  1-cycle pulse on debounced falling edge.
- long_press  out  N_CH  1-cycle pulse, once per press, after LONG_CYCLES of held level.
- toggle  out  N_CH  flips on each press.

Behaviour:
- One clock domain; reset is asynchronous and active-high. While `reset` is high:
  - synchroniser flops, debounce counters, hold counters and all outputs are 0;
  - deassertion is used as-is (an upstream reset synchroniser is the integrator's responsibility).
- Synchroniser: SYNC_STAGES-deep flop chain per channel. Call its output `s`.
- Debounce, per channel:
  - Counter `dc`, width clog2(DB_CYCLES+1).
  - When `s` equals `level`: `dc` is cleared to 0.
  - When `s` differs from `level`: `dc` increments.
  - On the edge where `s` has differed for DB_CYCLES consecutive edges: `level` takes `s` and `dc` clears.
  - Any return of `s` to `level` before that edge restarts the count from 0; the glitch is rejected.
- Latency: a clean raw transition held steady appears on `level` exactly SYNC_STAGES+DB_CYCLES rising edges after the first edge that samples it.
- press/release:
  - Registered, asserted in the same cycle `level` first shows its new value.
  - High for exactly 1 cycle.
  - Never asserted together on the same channel.
- Long press:
  - Hold counter `hc`, width clog2(LONG_CYCLES+1). Cleared while `level`=0; increments while `level`=1; saturates at LONG_CYCLES.
  - `long_press` pulses for 1 cycle exactly LONG_CYCLES cycles after the `press` pulse (same cycle `hc` reaches LONG_CYCLES).
  - At most one pulse per press, with no retrigger while held.
  - If the button is released first, no pulse is produced.
- Toggle:
  - `toggle[i]` inverts on `press[i]`.
  - `toggle_clr[i]` forces 0 on the next edge and has priority over a simultaneous press (result 0).
  - `toggle_clr` does not affect any other output.
- Reset mid-operation:
  - Every output drops to 0 immediately, with no release pulse.
  - If the button is still held after deassert, it is treated as a new press after the full latency.
- Channels never interact. Simultaneous events on different channels are all reported in the same cycle.

Test Plan (N_CH=4, SYNC_STAGES=2, DB_CYCLES=8, LONG_CYCLES=32):
1. Assert `reset` with `btn_in`=4'hF -> all outputs 0 during reset. Release reset, hold input -> `level`=4'hF and `press`=4'hF for one cycle, 10 edges after deassert.
2. `btn_in[0]` 0->1 held -> `level[0]` and `press[0]` rise on edge 10, `press[0]` low on edge 11, `toggle[0]` 0->1. Second clean press/release -> `toggle[0]` back to 0, `release[0]` 1-cycle pulse 10 edges after the raw fall.
3. `btn_in[1]` high for 7 cycles then low, repeated bouncing (3 high / 2 low) for 50 cycles -> `level[1]`, `press[1]` and `toggle[1]` stay 0 throughout.
4. `btn_in[2]` held 60 cycles past the `press` pulse -> exactly one `long_press[2]` pulse, 32 cycles after `press[2]`. Separate press released at 20 cycles -> no `long_press[2]`.
5. `toggle_clr[3]` asserted in the same cycle as `press[3]` while `toggle[3]`=0 -> `toggle[3]` stays 0. With `toggle[3]`=1 and clr -> 0 next cycle. Simultaneous presses on channels 0 and 3 -> both `press` bits high in the same cycle.
6. Assert `reset` for 3 cycles while channel 2 is held and `hc`=20 -> `level`, `toggle` and `long_press` drop immediately with no `release` pulse. After deassert -> new `press[2]` at edge 10, `long_press[2]` 32 cycles later.
